// File: rtl/pipe_pkg.sv
// Shared encodings and shadow-entry layout for the hazard/forwarding unit.
package pipe_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  localparam int unsigned ENTRY_W = REG_W + 2;
  localparam int unsigned STALL_CNT_W = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             rf_en;
    logic             load;
  } shadow_entry_t;

  // Register 0 is hard-wired, so an entry targeting it never produces a value.
  function automatic logic is_producer(input shadow_entry_t e);
    return e.rf_en && (e.dest != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// ID-stage request and hazard/forwarding control bundle.
interface hazard_fwd_unit_if;
  import pipe_pkg::*;

  logic [REG_W-1:0]       id_rs;
  logic [REG_W-1:0]       id_rt;
  logic                   id_uses_rs;
  logic                   id_uses_rt;
  logic [REG_W-1:0]       id_dest;
  logic                   id_rf_enable;
  logic                   id_load;
  logic                   ex_branch_taken;
  logic [1:0]             fwd_a_sel;
  logic [1:0]             fwd_b_sel;
  logic                   pc_le;
  logic                   ifid_le;
  logic                   idex_nop;
  logic                   ifid_clr;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_rf_enable, id_load,
           ex_branch_taken,
    input  fwd_a_sel, fwd_b_sel, pc_le, ifid_le, idex_nop, ifid_clr, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_rf_enable, id_load,
           ex_branch_taken,
    output fwd_a_sel, fwd_b_sel, pc_le, ifid_le, idex_nop, ifid_clr, stall_count
  );

endinterface

// File: rtl/dest_shadow_pipe.sv
// Three-deep shadow of in-flight destinations (EX, MEM, WB) with bubble insertion.
module dest_shadow_pipe
  import pipe_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  shadow_entry_t i_id_entry,
  input  logic          i_bubble,
  output shadow_entry_t o_ex,
  output shadow_entry_t o_mem,
  output shadow_entry_t o_wb
);

  logic [ENTRY_W-1:0] r_ex;
  logic [ENTRY_W-1:0] r_mem;
  logic [ENTRY_W-1:0] r_wb;
  logic [ENTRY_W-1:0] w_ex_next;

  assign w_ex_next = i_bubble ? '0 : i_id_entry;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_ex  <= w_ex_next;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  assign o_ex  = shadow_entry_t'(r_ex);
  assign o_mem = shadow_entry_t'(r_mem);
  assign o_wb  = shadow_entry_t'(r_wb);

endmodule

// File: rtl/hazard_fwd_unit.sv
// ID-stage forwarding select, load-use stall FSM and branch flush control.
module hazard_fwd_unit
  import pipe_pkg::*;
(
  input logic              clk,
  input logic              reset,
  hazard_fwd_unit_if.slave bus
);

  shadow_entry_t          w_id_entry;
  shadow_entry_t          w_ex;
  shadow_entry_t          w_mem;
  shadow_entry_t          w_wb;
  fwd_sel_e               w_fwd_a;
  fwd_sel_e               w_fwd_b;
  hz_state_e              r_state;
  hz_state_e              w_state_next;
  logic [STALL_CNT_W-1:0] r_stall_count;
  logic [STALL_CNT_W-1:0] w_stall_count_next;
  logic                   w_load_use;
  logic                   w_stall;
  logic                   w_flush;
  logic                   w_bubble;

  function automatic logic hit(input shadow_entry_t e, input logic [REG_W-1:0] src);
    return is_producer(e) && (e.dest == src);
  endfunction

  // Youngest producer wins: EX, then MEM, then WB, else the register file.
  function automatic fwd_sel_e pick(input logic used, input logic [REG_W-1:0] src,
                                    input shadow_entry_t ex, input shadow_entry_t mem,
                                    input shadow_entry_t wb);
    if (!used)            return FWD_RF;
    else if (hit(ex, src))  return FWD_EX;
    else if (hit(mem, src)) return FWD_MEM;
    else if (hit(wb, src))  return FWD_WB;
    else                    return FWD_RF;
  endfunction

  assign w_id_entry = {bus.id_dest, bus.id_rf_enable, bus.id_load};

  dest_shadow_pipe u_shadow (
    .clk        (clk),
    .reset      (reset),
    .i_id_entry (w_id_entry),
    .i_bubble   (w_bubble),
    .o_ex       (w_ex),
    .o_mem      (w_mem),
    .o_wb       (w_wb)
  );

  always_comb begin
    w_fwd_a    = pick(bus.id_uses_rs, bus.id_rs, w_ex, w_mem, w_wb);
    w_fwd_b    = pick(bus.id_uses_rt, bus.id_rt, w_ex, w_mem, w_wb);
    w_flush    = bus.ex_branch_taken;
    w_load_use = w_ex.load && ((bus.id_uses_rs && hit(w_ex, bus.id_rs)) ||
                               (bus.id_uses_rt && hit(w_ex, bus.id_rt)));
    // A taken branch discards the dependent instruction, so flush wins over stall.
    w_stall    = (r_state == RUN) && w_load_use && !w_flush;
    w_bubble   = w_stall || w_flush;
  end

  always_comb begin
    w_state_next       = r_state;
    w_stall_count_next = r_stall_count;
    case (r_state)
      RUN:   if (w_stall) w_state_next = STALL;
      STALL: w_state_next = RUN;
    endcase
    if (w_stall && (r_stall_count != STALL_CNT_MAX)) begin
      w_stall_count_next = r_stall_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= RUN;
      r_stall_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_stall_count <= w_stall_count_next;
    end
  end

  assign bus.fwd_a_sel   = w_fwd_a;
  assign bus.fwd_b_sel   = w_fwd_b;
  assign bus.pc_le       = !w_stall;
  assign bus.ifid_le     = !w_stall;
  assign bus.idex_nop    = w_bubble;
  assign bus.ifid_clr    = w_flush;
  assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: forwarding priority, load-use stall, flush, reset, saturation.
module tb_hazard_fwd_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  hazard_fwd_unit_if bus ();

  hazard_fwd_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic pc, input logic ifid, input logic nop,
                         input logic clr);
    chk({tag, ".pc_le"}, 16'(bus.pc_le), 16'(pc));
    chk({tag, ".ifid_le"}, 16'(bus.ifid_le), 16'(ifid));
    chk({tag, ".idex_nop"}, 16'(bus.idex_nop), 16'(nop));
    chk({tag, ".ifid_clr"}, 16'(bus.ifid_clr), 16'(clr));
  endtask

  // Apply one ID-stage instruction at the falling edge; outputs are checked 1ns later.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic [4:0] dest, input logic rfen,
                       input logic ld, input logic taken);
    @(negedge clk);
    bus.id_rs           = rs;
    bus.id_rt           = rt;
    bus.id_uses_rs      = urs;
    bus.id_uses_rt      = urt;
    bus.id_dest         = dest;
    bus.id_rf_enable    = rfen;
    bus.id_load         = ld;
    bus.ex_branch_taken = taken;
    #1;
  endtask

  initial begin
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
    bus.id_dest = '0; bus.id_rf_enable = 1'b0; bus.id_load = 1'b0;
    bus.ex_branch_taken = 1'b0;
    repeat (2) @(posedge clk);

    // Reset holds the shadow empty even when a load is presented
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    chk_ctl("rst0", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst0.count", bus.stall_count, 16'h0000);
    drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("rst1.fwd_a", 16'(bus.fwd_a_sel), 16'h0);
    chk("rst1.fwd_b", 16'(bus.fwd_b_sel), 16'h0);
    chk_ctl("rst1", 1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;

    // ALU producer r5 walks through EX, MEM, WB
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    drive(5'd5, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("ex5.fwd_a", 16'(bus.fwd_a_sel), 16'h1);
    chk("ex5.fwd_b_unused", 16'(bus.fwd_b_sel), 16'h0);
    chk_ctl("ex5", 1'b1, 1'b1, 1'b0, 1'b0);
    drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("mem5.fwd_a", 16'(bus.fwd_a_sel), 16'h2);
    chk("mem5.fwd_b", 16'(bus.fwd_b_sel), 16'h2);
    drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("wb5.fwd_a", 16'(bus.fwd_a_sel), 16'h3);
    chk("wb5.fwd_b", 16'(bus.fwd_b_sel), 16'h3);
    drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("gone5.fwd_a", 16'(bus.fwd_a_sel), 16'h0);

    // Two writers of r7: EX beats MEM, then MEM beats WB
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    drive(5'd7, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
    chk("prio_ex.fwd_a", 16'(bus.fwd_a_sel), 16'h1);
    drive(5'd7, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("r7_mem_wb.fwd_a", 16'(bus.fwd_a_sel), 16'h2);
    chk("r2_ex.fwd_b", 16'(bus.fwd_b_sel), 16'h1);
    drive(5'd7, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("r7_wb.fwd_a", 16'(bus.fwd_a_sel), 16'h3);
    chk("r2_mem.fwd_b", 16'(bus.fwd_b_sel), 16'h2);

    // Load r8 then a user of rt=8: one stall cycle, then MEM forwarding
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    drive(5'd0, 5'd8, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    chk_ctl("lu8", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("lu8.count_before", bus.stall_count, 16'h0000);
    drive(5'd0, 5'd8, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("lu8_stall.fwd_b", 16'(bus.fwd_b_sel), 16'h2);
    chk_ctl("lu8_stall", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lu8_stall.count", bus.stall_count, 16'h0001);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("lu8_after.count", bus.stall_count, 16'h0001);

    // r0 loads in every shadow slot are never producers
    repeat (3) drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("r0.fwd_a", 16'(bus.fwd_a_sel), 16'h0);
    chk("r0.fwd_b", 16'(bus.fwd_b_sel), 16'h0);
    chk_ctl("r0", 1'b1, 1'b1, 1'b0, 1'b0);

    // Load r3 with a dependent instruction while the branch resolves taken
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
    chk("r0_after.count", bus.stall_count, 16'h0001);
    drive(5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1);
    chk_ctl("flush", 1'b1, 1'b1, 1'b1, 1'b1);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("flush_after.count", bus.stall_count, 16'h0001);
    chk_ctl("flush_after", 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset asserted in the STALL cycle
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    drive(5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("lu_rs8.pc_le", 16'(bus.pc_le), 16'h0);
    drive(5'd8, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("stall_rs8.count", bus.stall_count, 16'h0002);
    chk("stall_rs8.fwd_a", 16'(bus.fwd_a_sel), 16'h2);
    reset = 1'b0;
    drive(5'd8, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    chk("post_rst.fwd_a", 16'(bus.fwd_a_sel), 16'h0);
    chk("post_rst.fwd_b", 16'(bus.fwd_b_sel), 16'h0);
    chk("post_rst.count", bus.stall_count, 16'h0000);
    chk_ctl("post_rst", 1'b1, 1'b1, 1'b0, 1'b0);

    // Preset the counter near saturation, then stall twice more
    @(negedge clk);
    force dut.r_stall_count = 16'hFFFE;
    #1;
    release dut.r_stall_count;
    chk("preset.count", bus.stall_count, 16'hFFFE);
    for (int k = 0; k < 2; k++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
      drive(5'd0, 5'd8, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("sat_lu.pc_le", 16'(bus.pc_le), 16'h0);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("sat.count", bus.stall_count, 16'hFFFF);
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("sat_hold.count", bus.stall_count, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have: clk  in  1  single clock; all state changes on posedge clk.
REQ-002 SHALL have: reset  in  1  synchronous, active-low reset, sampled on posedge clk.
REQ-003 SHALL have: id_rs, id_rt  in  5 each  ID-stage source register numbers.
REQ-004 SHALL have: id_uses_rs, id_uses_rt  in  1 each  ID instruction reads that source.
REQ-005 SHALL have: id_dest  in  5  ID destination (rd, rt or r31, already selected).
REQ-006 SHALL have: id_rf_enable, id_load  in  1 each  ID instruction writes RF / is a load.
REQ-007 SHALL have: ex_branch_taken  in  1  EX-stage condition handler resolved taken.
REQ-008 SHALL have: fwd_a_sel, fwd_b_sel  out  2 each  ID mux A/B select: 00 RF, 01 EX, 10 MEM, 11 WB.
REQ-009 SHALL have: pc_le, ifid_le  out  1 each  PC / IF-ID load enables.
REQ-010 SHALL have: idex_nop  out  1  forces the 22-bit control bundle into ID/EX to zero.
REQ-011 SHALL have: ifid_clr  out  1  clears IF/ID instruction on flush.
REQ-012 SHALL have: stall_count  out  16  saturating count of load-use stall cycles.

Function
REQ-013 SHALL keep a 3-entry destination shadow (EX, MEM, WB), each entry {dest[4:0], rf_en, load}.
REQ-014 SHALL advance the shadow every cycle: WB<=MEM, MEM<=EX, EX<=ID entry, or a zero (bubble) entry when idex_nop=1.
REQ-015 SHALL treat an entry as a producer only when rf_en=1 and dest!=0; register 0 is never forwarded or stalled on.
REQ-016 SHALL compute fwd_a_sel for id_rs combinationally with priority EX > MEM > WB > RF; fwd_b_sel likewise for id_rt.
REQ-017 SHALL force a select to 00 when the matching id_uses_* is 0.
REQ-018 SHALL detect load-use when the EX entry has load=1, is a producer, and matches a used source.
REQ-019 SHALL implement FSM RUN/STALL: RUN->STALL on load-use without ex_branch_taken; STALL->RUN unconditionally after one cycle.
REQ-020 SHALL, in the load-use cycle, drive pc_le=0, ifid_le=0, idex_nop=1; otherwise pc_le=ifid_le=1.
REQ-021 SHALL, in STALL, evaluate forwarding normally; the load is then in MEM and selects 10.
REQ-022 SHALL, on ex_branch_taken=1, drive ifid_clr=1, idex_nop=1, pc_le=1, ifid_le=1 and suppress load-use in that cycle (flush beats stall).
REQ-023 SHALL increment stall_count once per load-use cycle, saturating at 16'hFFFF without wrapping.
REQ-024 SHALL produce all outputs with zero-cycle latency from ID inputs and current shadow state.

Reset
REQ-025 SHALL, while reset=0 at posedge clk, clear all shadow entries to zero, FSM to RUN, and stall_count to 0.
REQ-026 SHALL hold pc_le=ifid_le=1, idex_nop=0, ifid_clr=0 and fwd selects=00 while the shadow is in its reset state.
REQ-027 SHALL abandon a pending STALL on reset mid-operation; the first cycle after release is RUN.

Structure
REQ-028 SHALL place FWD_RF/FWD_EX/FWD_MEM/FWD_WB encodings, the RUN/STALL encodings, REG_ZERO and the shadow-entry width in a shared package pipe_pkg.
REQ-029 SHALL implement the shadow in one sub-module dest_shadow_pipe (3-deep entry shift register with bubble insert); the compare/priority logic and FSM stay in the top module.

Verification
REQ-030 SHALL cover: EX entry dest=5 rf_en=1 load=0; ID rs=5 used -> fwd_a_sel=01, pc_le=1, idex_nop=0.
REQ-031 SHALL cover: EX load dest=8; ID rt=8 used -> one cycle pc_le=0, ifid_le=0, idex_nop=1, stall_count 0->1; next cycle fwd_b_sel=10, pc_le=1.
REQ-032 SHALL cover: dest=0 with rf_en=1 in EX/MEM/WB; ID rs=rt=0 used -> both selects 00, no stall.
REQ-033 SHALL cover: EX load dest=3, ID rs=3, ex_branch_taken=1 in the same cycle -> ifid_clr=1, idex_nop=1, pc_le=1, stall_count unchanged.
REQ-034 SHALL cover: reg 7 in MEM and WB, not EX; ID rs=7 -> fwd_a_sel=10; then reset=0 during a STALL -> next cycle RUN, selects 00, stall_count=0.
REQ-035 SHALL cover: stall_count preset to 16'hFFFE via repeated load-use stalls -> two more stalls give 16'hFFFF and it stays 16'hFFFF.
